alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter NREGS, default 8, the register-file depth; 3-bit register indices, no other value supported.
REQ-002 The module SHALL have port clk2  input  1  sole clock; all state updates on rising edge.
REQ-003 The module SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 The module SHALL have port cmd_valid  input  1  command word present.
REQ-005 The module SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-006 The module SHALL have port cmd_word  input  16  fields op[15:12], dst[11:9], srcA[8:6], srcB[5:3], bit[2:0].
REQ-007 The module SHALL have port alu_inst  output  4  opcode to the ALU.
REQ-008 The module SHALL have port alu_a / alu_b  output  8 each  ALU operands, from regfile[srcA] / regfile[srcB].
REQ-009 The module SHALL have port alu_bit  output  3  bit index for set-bit/clear-bit.
REQ-010 The module SHALL have port alu_we  output  1  ALU write-enable strobe, high only in EXEC.
REQ-011 The module SHALL have port alu_ans  input  8  ALU result.
REQ-012 The module SHALL have port alu_carry  input  1  ALU carry (result bit 8).
REQ-013 The module SHALL have port rsp_valid  output  1  result available.
REQ-014 The module SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-015 The module SHALL have port rsp_data  output  8  value written to dst.
REQ-016 The module SHALL have port rsp_carry  output  1  carry flag after the command.
REQ-017 The module SHALL have port carry_flag  output  1  current architectural carry flag.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, EXEC, WRITE, RESP.
- IDLE: cmd_ready=1; on cmd_valid, latch cmd_word -> FETCH.
- FETCH: register regfile[srcA], regfile[srcB] into alu_a/alu_b -> EXEC.
- EXEC: drive alu_inst, alu_bit; alu_we=1 -> WRITE.
- WRITE: capture alu_ans into regfile[dst] and rsp_data -> RESP.
REQ-019 RESP SHALL hold rsp_valid=1 and stable rsp_data/rsp_carry until rsp_ready=1, then -> IDLE; when rsp_valid and rsp_ready are both high, the return to IDLE SHALL occur that same edge.
REQ-020 Accept-to-rsp_valid latency SHALL be exactly 4 clk2 cycles; cmd_ready SHALL be 0 in all states except IDLE; cmd_word SHALL be ignored outside IDLE.
REQ-021 carry_flag SHALL update from alu_carry in WRITE only for ops 2,3,5,6 (add, sub, inc, dec) and 8,15 (rotates); all other ops SHALL leave it unchanged.
REQ-022 srcA==srcB SHALL present the same register value on both operands; dst equal to a source SHALL be written only in WRITE, so operands stay pre-write values.
REQ-023 Op 9 SHALL write 0x00 to dst; ops 0/1 (pass b / pass a) SHALL still write dst.
REQ-024 The regfile SHALL be 8x8 bits with 2 combinational read ports and 1 synchronous write port, and no hardwired-zero register.
REQ-025 Reset asserted mid-command SHALL abort the command: no regfile write and no response.

Reset
REQ-026 While reset=0: state=IDLE, cmd_ready=1, rsp_valid=0, alu_we=0, alu_inst=0, alu_a=alu_b=0, alu_bit=0, rsp_data=0, rsp_carry=0, carry_flag=0, and all registers=0x00.
REQ-027 Reset SHALL take effect asynchronously; release SHALL be sampled on the clk2 edge, and the first accept SHALL be possible on the first edge after release.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the opcode enum (16 values), the state enum, the command field positions and widths, and the set of carry-updating ops.
REQ-029 The regfile SHALL be the sub-module alu_regfile, 2R1W, with the same clk2/reset convention.

Verification
REQ-030 After reset, issue add r2<=r0+r1 (r0=0x0F, r1=0xF1 preloaded via pass ops) -> rsp_data=0x00, rsp_carry=1, rsp_valid exactly 4 cycles after accept.
REQ-031 Issue set-bit bit=7 on r3=0x00, dst=r3 -> rsp_data=0x80; then clear-bit bit=7 -> 0x00, carry_flag unchanged.
REQ-032 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, and a cmd_valid pulse ignored.
REQ-033 Run xor r4<=r4^r4 with r4=0xA5 -> rsp_data=0x00, r4=0x00 afterwards, carry_flag unchanged.
REQ-034 Assert reset during EXEC of inc r5 (r5=0x10) -> r5=0x00, rsp_valid never rises, cmd_ready=1 immediately.
REQ-035 Issue back-to-back commands with rsp_ready tied high -> accepts spaced exactly 5 cycles apart.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types, command layout and carry-op set for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned BIT_W     = 3;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned CMD_W     = 16;

    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned DST_LSB  = 9;
    localparam int unsigned SRCA_LSB = 6;
    localparam int unsigned SRCB_LSB = 3;
    localparam int unsigned BIT_LSB  = 0;

    typedef enum logic [OP_W-1:0] {
        OP_PASSB = 4'd0,  OP_PASSA = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3,
        OP_AND   = 4'd4,  OP_INC   = 4'd5,  OP_DEC  = 4'd6,  OP_OR   = 4'd7,
        OP_ROL   = 4'd8,  OP_ZERO  = 4'd9,  OP_XOR  = 4'd10, OP_NOT  = 4'd11,
        OP_SETB  = 4'd12, OP_CLRB  = 4'd13, OP_SWAP = 4'd14, OP_ROR  = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    typedef struct packed {
        op_e                  op;
        logic [REG_IDX_W-1:0] dst;
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
        logic [BIT_W-1:0]     bit_idx;
    } cmd_t;

    // One bit per opcode: add, sub, inc, dec and both rotates update carry
    localparam logic [15:0] CARRY_OPS = 16'b1000_0001_0110_1100;

    function automatic logic is_carry_op(input op_e op);
        return CARRY_OPS[op];
    endfunction

    function automatic cmd_t decode_cmd(input logic [CMD_W-1:0] w);
        cmd_t c;
        c.op      = op_e'(w[OP_LSB +: OP_W]);
        c.dst     = w[DST_LSB  +: REG_IDX_W];
        c.src_a   = w[SRCA_LSB +: REG_IDX_W];
        c.src_b   = w[SRCB_LSB +: REG_IDX_W];
        c.bit_idx = w[BIT_LSB  +: BIT_W];
        return c;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command, ALU and response signals between the sequencer and its host/ALU.
interface alu_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_word;
    logic [OP_W-1:0]   alu_inst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [BIT_W-1:0]  alu_bit;
    logic              alu_we;
    logic [DATA_W-1:0] alu_ans;
    logic              alu_carry;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;

    modport master (
        output cmd_valid, cmd_word, alu_ans, alu_carry, rsp_ready,
        input  cmd_ready, alu_inst, alu_a, alu_b, alu_bit, alu_we,
               rsp_valid, rsp_data, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_word, alu_ans, alu_carry, rsp_ready,
        output cmd_ready, alu_inst, alu_a, alu_b, alu_bit, alu_we,
               rsp_valid, rsp_data, rsp_carry
    );
endinterface

// File: rtl/alu_regfile.sv
// 8x8 register file: two combinational read ports, one synchronous write port.
module alu_regfile
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREGS = 8
) (
    input  logic                 clk2,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_a_c,
    output logic [DATA_W-1:0]    rdata_b_c
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a_c = regs[raddr_a];
    assign rdata_b_c = regs[raddr_b];

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one command at a time: fetch operands, strobe the ALU, write back, respond.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREGS = 8
) (
    input  logic           clk2,
    input  logic           reset,
    alu_sequencer_if.slave bus,
    output logic           carry_flag
);

    state_e            state;
    state_e            state_nxt;
    cmd_t              cmd_q;
    logic              load_cmd_c;
    logic              load_ops_c;
    logic              rf_we_c;
    logic              cmd_ready_d;
    logic              alu_we_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk2      (clk2),
        .reset     (reset),
        .we        (rf_we_c),
        .waddr     (cmd_q.dst),
        .wdata     (bus.alu_ans),
        .raddr_a   (cmd_q.src_a),
        .raddr_b   (cmd_q.src_b),
        .rdata_a_c (rd_a_c),
        .rdata_b_c (rd_b_c)
    );

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.cmd_valid) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered flags are decoded from the next state so they line up with it
    always_comb begin
        load_cmd_c  = 1'b0;
        load_ops_c  = 1'b0;
        rf_we_c     = 1'b0;
        cmd_ready_d = (state_nxt == ST_IDLE);
        alu_we_d    = (state_nxt == ST_EXEC);
        rsp_valid_d = (state_nxt == ST_RESP);
        case (state)
            ST_IDLE:  load_cmd_c = bus.cmd_valid;
            ST_FETCH: load_ops_c = 1'b1;
            ST_WRITE: rf_we_c    = 1'b1;
            default:  ;
        endcase
    end

    // ALU controls stay held through WRITE so the combinational result is stable
    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            cmd_q         <= '0;
            bus.cmd_ready <= 1'b1;
            bus.alu_we    <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.alu_inst  <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_bit   <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            carry_flag    <= 1'b0;
        end else begin
            bus.cmd_ready <= cmd_ready_d;
            bus.alu_we    <= alu_we_d;
            bus.rsp_valid <= rsp_valid_d;
            if (load_cmd_c) cmd_q <= decode_cmd(bus.cmd_word);
            if (load_ops_c) begin
                bus.alu_a    <= rd_a_c;
                bus.alu_b    <= rd_b_c;
                bus.alu_inst <= cmd_q.op;
                bus.alu_bit  <= cmd_q.bit_idx;
            end
            if (rf_we_c) begin
                bus.rsp_data <= bus.alu_ans;
                if (is_carry_op(cmd_q.op)) begin
                    carry_flag    <= bus.alu_carry;
                    bus.rsp_carry <= bus.alu_carry;
                end else begin
                    bus.rsp_carry <= carry_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed scoreboard bench for alu_sequencer with a behavioural ALU.
module tb_alu_sequencer;

    typedef struct {
        logic [7:0] data;
        logic       carry;
        int         acc;
    } exp_t;

    logic clk2 = 1'b0;
    logic reset;
    logic carry_flag;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;
    exp_t exp_q[$];
    logic [7:0] ref_regs [8];
    logic       ref_carry;
    logic       in_rsp = 1'b0;
    logic [7:0] mon_data;
    logic       mon_carry;
    logic [8:0] alu_r;

    alu_sequencer_if bus ();

    alu_sequencer #(.NREGS(8)) dut (
        .clk2       (clk2),
        .reset      (reset),
        .bus        (bus),
        .carry_flag (carry_flag)
    );

    always #5 clk2 = ~clk2;
    always @(posedge clk2) cyc <= cyc + 1;

    function automatic logic carry_op(input logic [3:0] op);
        return op inside {4'd2, 4'd3, 4'd5, 4'd6, 4'd8, 4'd15};
    endfunction

    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] bi);
        logic [7:0] m;
        m = 8'd1 << bi;
        case (op)
            4'd0:    return {1'b0, b};
            4'd1:    return {1'b0, a};
            4'd2:    return {1'b0, a} + {1'b0, b};
            4'd3:    return {1'b0, a} - {1'b0, b};
            4'd4:    return {1'b0, a & b};
            4'd5:    return {1'b0, a} + 9'd1;
            4'd6:    return {1'b0, a} - 9'd1;
            4'd7:    return {1'b0, a | b};
            4'd8:    return {a[7], a[6:0], a[7]};
            4'd9:    return 9'd0;
            4'd10:   return {1'b0, a ^ b};
            4'd11:   return {1'b0, ~a};
            4'd12:   return {1'b0, a | m};
            4'd13:   return {1'b0, a & ~m};
            4'd14:   return {1'b0, a[3:0], a[7:4]};
            default: return {a[0], a[0], a[7:1]};
        endcase
    endfunction

    // Stand-in ALU; for non-carry ops it offers the inverted flag so a stray update shows
    always_comb begin
        alu_r         = alu_fn(bus.alu_inst, bus.alu_a, bus.alu_b, bus.alu_bit);
        bus.alu_ans   = alu_r[7:0];
        bus.alu_carry = carry_op(bus.alu_inst) ? alu_r[8] : ~carry_flag;
    end

    always @(posedge clk2) begin
        #1;
        case (ready_mode)
            0:       bus.rsp_ready = 1'b0;
            1:       bus.rsp_ready = 1'b1;
            default: bus.rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int dst, input int sa,
                                       input int sb, input int bi);
        return {4'(op), 3'(dst), 3'(sa), 3'(sb), 3'(bi)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
        ref_carry = 1'b0;
        exp_q.delete();
    endtask

    task automatic issue(input logic [15:0] w, output int acc, output int waited);
        logic [8:0] r;
        exp_t       e;
        waited = 0;
        @(negedge clk2);
        bus.cmd_valid = 1'b1;
        bus.cmd_word  = w;
        while (!bus.cmd_ready && waited < 60) begin
            @(negedge clk2);
            waited++;
        end
        acc = cyc;
        chk("cmd_accept", 32'(bus.cmd_ready), 1);
        if (bus.cmd_ready) begin
            r = alu_fn(w[15:12], ref_regs[w[8:6]], ref_regs[w[5:3]], w[2:0]);
            ref_regs[w[11:9]] = r[7:0];
            if (carry_op(w[15:12])) ref_carry = r[8];
            e.data  = r[7:0];
            e.carry = ref_carry;
            e.acc   = acc;
            exp_q.push_back(e);
        end
        @(posedge clk2);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_word  = 16'($urandom);
    endtask

    task automatic send(input logic [15:0] w);
        int a;
        int n;
        issue(w, a, n);
    endtask

    task automatic load_reg(input int idx, input logic [7:0] val);
        send(mk(9, idx, 0, 0, 0));
        for (int b = 0; b < 8; b++) begin
            if (val[b]) send(mk(12, idx, idx, idx, b));
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 500) begin
            @(negedge clk2);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    // Monitor: latency, hold stability and result comparison against the queue head
    always @(negedge clk2) begin
        if (!reset) begin
            in_rsp = 1'b0;
        end else begin
            if (bus.alu_we && exp_q.size() != 0)
                chk("we_timing", 32'(cyc - exp_q[$].acc), 2);
            if (bus.rsp_valid) begin
                chk("cmd_ready_in_resp", 32'(bus.cmd_ready), 0);
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'(bus.rsp_valid), 0);
                end else begin
                    if (!in_rsp) begin
                        in_rsp    = 1'b1;
                        mon_data  = bus.rsp_data;
                        mon_carry = bus.rsp_carry;
                        chk("rsp_latency", 32'(cyc - exp_q[0].acc), 4);
                    end else begin
                        chk("rsp_data_stable", 32'(bus.rsp_data), 32'(mon_data));
                        chk("rsp_carry_stable", 32'(bus.rsp_carry), 32'(mon_carry));
                    end
                    if (bus.rsp_ready) begin
                        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
                        chk("rsp_carry", 32'(bus.rsp_carry), 32'(exp_q[0].carry));
                        chk("carry_flag", 32'(carry_flag), 32'(exp_q[0].carry));
                        void'(exp_q.pop_front());
                        in_rsp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int n;
        int prev;
        logic [7:0] hold_data;
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_word  = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk2);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_alu_we", 32'(bus.alu_we), 0);
        chk("rst_alu_inst", 32'(bus.alu_inst), 0);
        chk("rst_alu_a", 32'(bus.alu_a), 0);
        chk("rst_alu_b", 32'(bus.alu_b), 0);
        chk("rst_alu_bit", 32'(bus.alu_bit), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_carry", 32'(bus.rsp_carry), 0);
        chk("rst_carry_flag", 32'(carry_flag), 0);
        @(posedge clk2);
        #2 reset = 1'b1;
        ready_mode = 1;

        // add with carry-out wrapping to zero
        issue(mk(1, 0, 0, 0, 0), a, n);
        chk("first_accept_after_release", 32'(n), 0);
        load_reg(0, 8'h0F);
        load_reg(1, 8'hF1);
        send(mk(2, 2, 0, 1, 0));
        wait_idle();

        // set and clear bit 7 of r3
        send(mk(9, 3, 0, 0, 0));
        send(mk(12, 3, 3, 0, 7));
        send(mk(13, 3, 3, 0, 7));
        wait_idle();

        // response held by consumer; stray command pulse must be ignored
        ready_mode = 0;
        send(mk(1, 6, 0, 0, 0));
        n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(negedge clk2);
            n++;
        end
        chk("hold_valid_rise", 32'(bus.rsp_valid), 1);
        hold_data = bus.rsp_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk2);
            if (k == 1) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_word  = mk(9, 0, 0, 0, 0);
            end
            if (k == 2) bus.cmd_valid = 1'b0;
            chk("hold_valid", 32'(bus.rsp_valid), 1);
            chk("hold_data", 32'(bus.rsp_data), 32'(hold_data));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        ready_mode = 1;
        wait_idle();
        send(mk(1, 0, 0, 0, 0));
        wait_idle();

        // self-xor clears the register without touching carry
        load_reg(4, 8'hA5);
        send(mk(10, 4, 4, 4, 0));
        send(mk(1, 4, 4, 4, 0));
        wait_idle();

        // random commands with random consumer back-pressure
        ready_mode = 2;
        for (int i = 0; i < 40; i++) send(16'($urandom));
        ready_mode = 1;
        wait_idle();

        // back-to-back accepts with the consumer always ready
        issue(16'($urandom), prev, n);
        for (int i = 0; i < 5; i++) begin
            issue(16'($urandom), a, n);
            chk("b2b_spacing", 32'(a - prev), 5);
            prev = a;
        end
        wait_idle();

        // reset during EXEC of inc r5 aborts it
        load_reg(5, 8'h10);
        wait_idle();
        send(mk(5, 5, 5, 0, 0));
        n = 0;
        while (!bus.alu_we && n < 10) begin
            @(negedge clk2);
            n++;
        end
        chk("reached_exec", 32'(bus.alu_we), 1);
        reset = 1'b0;
        model_reset();
        #1;
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("abort_carry_flag", 32'(carry_flag), 0);
        repeat (2) @(negedge clk2);
        chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
        @(posedge clk2);
        #2 reset = 1'b1;
        issue(mk(1, 5, 5, 5, 0), a, n);
        chk("accept_after_abort", 32'(n), 0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
